// File: rtl/multicycle_alu.sv
// rtl/multicycle_alu.sv - registered ALU with iterative unsigned multiply/divide
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request, sampled only while busy=0
//   aluCtr            operation select, sampled with start
//   input1, input2    operands A and B, sampled with start
//   aluRes            result; low product word for MULTU, quotient for DIVU
//   hiRes             high product word for MULTU, remainder for DIVU, else 0
//   zero              aluRes==0 for the committed result
//   busy              operation in flight
//   done              one-cycle pulse while the committed result is presented
module multicycle_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       aluCtr,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    output logic [WIDTH-1:0] aluRes,
    output logic [WIDTH-1:0] hiRes,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_NOR   = 4'b1100;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] b_reg;    // multiplicand / divisor
    logic [WIDTH-1:0] hi_reg;   // running high product / partial remainder
    logic [WIDTH-1:0] lo_reg;   // multiplier shifting out, product shifting in / dividend out, quotient in
    logic [CNT_W-1:0] cnt;

    logic             last;
    logic [WIDTH-1:0] single_res;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    logic [WIDTH:0]   div_rs;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi, div_lo;

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        single_res = '0;
        case (aluCtr)
            OP_ADD:  single_res = input1 + input2;
            OP_SUB:  single_res = input1 - input2;
            OP_AND:  single_res = input1 & input2;
            OP_OR:   single_res = input1 | input2;
            OP_SLTU: single_res = WIDTH'(input1 < input2);
            OP_NOR:  single_res = ~(input1 | input2);
            default: single_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier LSB is set, then shift the whole {hi,lo} pair right by one.
    assign mul_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], lo_reg[WIDTH-1:1]};

    // Restoring step: bring in the next dividend bit; subtract the divisor
    // only when it fits. The difference is below the divisor, so WIDTH bits suffice.
    assign div_rs   = {hi_reg, lo_reg[WIDTH-1]};
    assign div_ge   = (div_rs >= {1'b0, b_reg});
    assign div_diff = div_rs[WIDTH-1:0] - b_reg;
    assign div_hi   = div_ge ? div_diff : div_rs[WIDTH-1:0];
    assign div_lo   = {lo_reg[WIDTH-2:0], div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == FIN);
        case (state)
            IDLE: if (start) begin
                case (aluCtr)
                    OP_MULTU: state_nxt = MUL;
                    OP_DIVU:  state_nxt = (input2 != '0) ? DIV : FIN;
                    default:  state_nxt = FIN;
                endcase
            end
            MUL:  if (last) state_nxt = FIN;
            DIV:  if (last) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg  <= '0;
            hi_reg <= '0;
            lo_reg <= '0;
            cnt    <= '0;
            aluRes <= '0;
            hiRes  <= '0;
            zero   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (start) begin
                    b_reg  <= input2;
                    hi_reg <= '0;
                    lo_reg <= input1;
                    cnt    <= '0;
                    if (aluCtr == OP_DIVU) begin
                        if (input2 == '0) begin
                            aluRes <= '1;
                            hiRes  <= input1;
                            zero   <= 1'b0;
                        end
                    end else if (aluCtr != OP_MULTU) begin
                        aluRes <= single_res;
                        hiRes  <= '0;
                        zero   <= (single_res == '0);
                    end
                end
                MUL: begin
                    hi_reg <= mul_hi;
                    lo_reg <= mul_lo;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        aluRes <= mul_lo;
                        hiRes  <= mul_hi;
                        zero   <= (mul_lo == '0);
                    end
                end
                DIV: begin
                    hi_reg <= div_hi;
                    lo_reg <= div_lo;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        aluRes <= div_lo;
                        hiRes  <= div_hi;
                        zero   <= (div_lo == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// tb/tb_multicycle_alu.sv - scoreboard bench for multicycle_alu at WIDTH 32 and 8
module tb_multicycle_alu;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start32 = 0, start8 = 0;
    logic [3:0]  ctr32 = 0, ctr8 = 0;
    logic [31:0] in1_32 = 0, in2_32 = 0, res32, hi32;
    logic [7:0]  in1_8 = 0, in2_8 = 0, res8, hi8;
    logic        zero32, busy32, done32, zero8, busy8, done8;

    multicycle_alu #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .aluCtr(ctr32),
        .input1(in1_32), .input2(in2_32), .aluRes(res32), .hiRes(hi32),
        .zero(zero32), .busy(busy32), .done(done32)
    );

    multicycle_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .aluCtr(ctr8),
        .input1(in1_8), .input2(in2_8), .aluRes(res8), .hiRes(hi8),
        .zero(zero8), .busy(busy8), .done(done8)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] hi;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural reference: plain arithmetic on wide integers.
    task automatic model(input int w, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output exp_t e);
        longint unsigned mask, p, aa, bb;
        int lat;
        mask = (w == 32) ? 64'hFFFF_FFFF : 64'hFF;
        aa = a & mask;
        bb = b & mask;
        e.alu = 0;
        e.hi = 0;
        lat = 1;
        case (op)
            4'b0010: e.alu = 32'((aa + bb) & mask);
            4'b0110: e.alu = 32'((aa - bb) & mask);
            4'b0000: e.alu = 32'(aa & bb);
            4'b0001: e.alu = 32'(aa | bb);
            4'b0111: e.alu = (aa < bb) ? 1 : 0;
            4'b1100: e.alu = 32'(~(aa | bb) & mask);
            4'b1000: begin
                p = aa * bb;
                e.alu = 32'(p & mask);
                e.hi = 32'((p >> w) & mask);
                lat = w + 1;
            end
            4'b1001: begin
                if (bb == 0) begin
                    e.alu = 32'(mask);
                    e.hi = 32'(aa);
                end else begin
                    e.alu = 32'(aa / bb);
                    e.hi = 32'(aa % bb);
                    lat = w + 1;
                end
            end
            default: ;
        endcase
        e.z = (e.alu == 0);
        e.cyc = cyc + lat;
    endtask

    // Called at a negedge; returns at the negedge following the start edge.
    task automatic issue(input bit w8, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit push);
        exp_t e;
        int n = 0;
        while ((w8 ? busy8 : busy32) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("issue_wait_timeout", 1, 0);
        if (w8) begin
            start8 = 1; ctr8 = op; in1_8 = a[7:0]; in2_8 = b[7:0];
        end else begin
            start32 = 1; ctr32 = op; in1_32 = a; in2_32 = b;
        end
        if (push) begin
            model(w8 ? 8 : 32, op, a, b, e);
            if (w8) q8.push_back(e);
            else    q32.push_back(e);
        end
        @(negedge clk);
        start8 = 0; start32 = 0;
        in1_32 = $urandom; in2_32 = $urandom;
        in1_8 = 8'($urandom); in2_8 = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0 || busy32 || busy8) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queues_empty", 64'(q32.size() + q8.size()), 0);
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done32) begin
                if (q32.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_done32: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = q32.pop_front();
                    chk("res32", res32, e.alu);
                    chk("hi32", hi32, e.hi);
                    chk("zero32", zero32, e.z);
                    chk("done_cycle32", cyc, e.cyc);
                    chk("busy_at_done32", busy32, 1);
                end
            end
            if (done8) begin
                if (q8.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL spurious_done8: got done=1 expected no pulse (cycle %0d)", cyc);
                end else begin
                    e = q8.pop_front();
                    chk("res8", res8, e.alu[7:0]);
                    chk("hi8", hi8, e.hi[7:0]);
                    chk("zero8", zero8, e.z);
                    chk("done_cycle8", cyc, e.cyc);
                    chk("busy_at_done8", busy8, 1);
                end
            end
        end
    end

    logic [3:0] ops [10] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111,
                             4'b1100, 4'b1000, 4'b1001, 4'b1111, 4'b0011};

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_res32", res32, 0);
        chk("rst_hi32", hi32, 0);
        chk("rst_zero32", zero32, 1);
        chk("rst_busy32", busy32, 0);
        chk("rst_done32", done32, 0);
        chk("rst_zero8", zero8, 1);
        chk("rst_busy8", busy8, 0);
        rst_n = 1;
        @(negedge clk);

        // Directed single-cycle ops and divides at WIDTH=32
        issue(0, 4'b0010, 32'hFFFF_FFFF, 32'h1, 1);
        issue(0, 4'b0110, 32'd5, 32'd7, 1);
        issue(0, 4'b1100, 32'h0, 32'h0, 1);
        issue(0, 4'b0111, 32'd3, 32'hFFFF_FFFF, 1);
        issue(0, 4'b1111, 32'h1234, 32'h5678, 1);
        issue(0, 4'b1001, 32'd100, 32'd7, 1);
        issue(0, 4'b1001, 32'd9, 32'd0, 1);
        drain();

        // MULTU max*max: busy profile, ignored starts and operand toggling mid-flight
        issue(0, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        for (int k = 1; k <= 33; k++) begin
            chk("mul_busy_high", busy32, 1);
            if (k == 5) begin
                start32 = 1; ctr32 = 4'b0010; in1_32 = $urandom; in2_32 = $urandom;
            end
            if (k == 6) begin
                ctr32 = 4'b1000; in1_32 = 32'd3; in2_32 = 32'd4;
            end
            if (k == 8) start32 = 0;
            @(negedge clk);
        end
        chk("mul_busy_low_after", busy32, 0);
        drain();

        // WIDTH=8: multiply and back-to-back adds every 2 cycles
        issue(1, 4'b1000, 32'd200, 32'd200, 1);
        drain();
        for (int i = 0; i < 5; i++) issue(1, 4'b0010, $urandom, $urandom, 1);
        drain();

        // Reset in the middle of a multiply
        issue(0, 4'b1000, 32'd5, 32'd7, 0);
        repeat (9) @(negedge clk);
        rst_n = 0;
        #1;
        chk("midrst_res32", res32, 0);
        chk("midrst_hi32", hi32, 0);
        chk("midrst_zero32", zero32, 1);
        chk("midrst_busy32", busy32, 0);
        chk("midrst_done32", done32, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);

        // Random ops on both widths
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic [3:0] op;
            bit w8;
            w8 = (i % 2) == 1;
            op = ops[$urandom_range(0, 9)];
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 300));
            issue(w8, op, a, b, 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised registered ALU for the multi-cycle datapath.
- Keeps the single-cycle operation set: add, sub, and, or, set-less-than, nor.
- Adds iterative unsigned multiply and divide, producing a double-width HI/LO result.
- Sits between the register-file read stage and writeback. The control FSM issues `start` and waits for `done` before writeback.

Parameters:
- WIDTH, 32: operand and result width; must be ≥4.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only while busy=0.
- aluCtr  input  4  operation select, sampled with start.
- input1  input  WIDTH  operand A, sampled with start.
- input2  input  WIDTH  operand B, sampled with start.
- aluRes  output  WIDTH  result: low word for MULTU, quotient for DIVU.
- hiRes  output  WIDTH  high word for MULTU, remainder for DIVU; 0 for all other ops.
- zero  output  1  set when aluRes==0; computed for every operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when aluRes/hiRes/zero are valid.

Behaviour:
- Reset (rst_n=0, asynchronous): FSM→IDLE; aluRes=0, hiRes=0, zero=1, busy=0, done=0; counter and internal operand registers cleared.
- Reset asserted mid-operation: operation aborted; no done pulse; partial result discarded.
- Encoding of aluCtr:
  - 0010 ADD: A+B, modulo 2^WIDTH.
  - 0110 SUB: A−B, modulo 2^WIDTH.
  - 0000 AND.
  - 0001 OR.
  - 0111 SLTU: 1 if A<B unsigned, else 0.
  - 1100 NOR.
  - 1000 MULTU.
  - 1001 DIVU.
  - Any other code: aluRes=0, hiRes=0, treated as a single-cycle op.
- FSM states: IDLE, MUL, DIV, FIN.
  - IDLE: start=1 captures A, B and aluCtr.
    - Single-cycle op or illegal code: result registered at that edge; go to FIN.
    - MULTU: go to MUL.
    - DIVU with B≠0: go to DIV.
    - DIVU with B==0: aluRes = all ones, hiRes = A; go to FIN.
  - MUL: shift-add, one multiplier bit per cycle, LSB first, WIDTH iterations; after the last iteration go to FIN.
  - DIV: restoring division, one quotient bit per cycle, MSB first, WIDTH iterations; after the last iteration go to FIN.
  - FIN: done=1 for exactly this cycle; next state IDLE.
- Latency, with the start edge as cycle 0:
  - Single-cycle ops and divide-by-zero: done high in cycle 1.
  - MULTU and DIVU: done high in cycle WIDTH+1.
- Busy behaviour:
  - busy=1 from cycle 1 up to and including the FIN cycle; otherwise 0.
  - start while busy=1 is ignored; no queueing.
  - start in the cycle immediately after FIN is accepted, giving back-to-back single-cycle ops every 2 cycles.
- Outputs aluRes, hiRes and zero are updated only when the result is committed (entry to FIN). They hold their value until the next commit.
- Operand changes after the start edge do not affect the in-flight result.
- MULTU: {hiRes,aluRes} = A×B, full 2·WIDTH-bit product, no overflow.
- DIVU: aluRes = A/B, hiRes = A%B, both unsigned.
- ADD/SUB: no overflow flag; carry-out discarded.

Test Plan:
- Reset mid-MULTU: start MULTU A=5, B=7; assert rst_n=0 at cycle 10 → outputs immediately at reset values, busy=0; no done pulse after release.
- Single-cycle ops, WIDTH=32: ADD 0xFFFFFFFF+1 → aluRes=0, zero=1, done in cycle 1. SUB 5−7 → 0xFFFFFFFE, zero=0. NOR 0,0 → 0xFFFFFFFF. SLTU 3,0xFFFFFFFF → 1. Illegal aluCtr=1111 → 0, zero=1.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hiRes=0xFFFFFFFE, aluRes=0x00000001; done exactly in cycle 33; busy high cycles 1–33.
- DIVU 100/7 → aluRes=14, hiRes=2, done in cycle 33. DIVU 9/0 → aluRes=0xFFFFFFFF, hiRes=9, done in cycle 1.
- Start asserted during MUL with different operands, and input1/input2 toggled mid-operation → original product unaffected; ignored request produces no extra done pulse.
- WIDTH=8 instance: MULTU 200×200 → hiRes=0x9C, aluRes=0x40, done in cycle 9. Back-to-back ADDs issued every 2 cycles → each produces exactly one done pulse.
